// File: rtl/mdu_if.sv
// Operand/control bundle between the execute stage and the multiply/divide unit.
// The CPU side drives the op and operands; the MDU returns busy and HI/LO.
interface mdu_if;
    logic [2:0]  mdu_op;
    logic        start;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mdu_op, start, flush, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  mdu_op, start, flush, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, 32 RUN cycles plus one FIXUP cycle.
module mdu (
    input  logic clk,
    input  logic nrst,
    mdu_if.slave bus
);
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    logic        go;
    logic        is_md;
    logic        is_sgn;
    logic        is_dv;
    logic        b_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] trial;
    logic [63:0] acc_nx;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    // Decode: bit 2 clear selects mul/div, bit 1 divide, bit 0 signed.
    assign go     = bus.start & ~bus.flush & (state == IDLE);
    assign is_md  = ~bus.mdu_op[2];
    assign is_dv  = bus.mdu_op[1];
    assign is_sgn = bus.mdu_op[0];
    assign b_zero = (bus.b == 32'd0);
    assign abs_a  = (is_sgn & bus.a[31]) ? -bus.a : bus.a;
    assign abs_b  = (is_sgn & bus.b[31]) ? -bus.b : bus.b;

    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        trial   = acc[63:31] - {1'b0, opnd};
        acc_nx  = acc;
        if (is_div) begin
            if (!trial[32])
                acc_nx = {trial[31:0], acc[30:0], 1'b1};
            else
                acc_nx = {acc[62:0], 1'b0};
        end else begin
            acc_nx = {mul_sum, acc[31:1]};
        end
    end

    // Divide by zero keeps the raw unsigned result untouched.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = acc[31:0];
        rem  = acc[63:32];
        if (!div_zero) begin
            if (neg_q)
                quo = -acc[31:0];
            if (neg_r)
                rem = -acc[63:32];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (go && is_md)
                    state_nx = RUN;
            end
            RUN: begin
                if (bus.flush)
                    state_nx = IDLE;
                else if (cnt == 5'd31)
                    state_nx = FIXUP;
            end
            FIXUP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            busy_q <= 1'b0;
        else
            busy_q <= (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (go && is_md) begin
                cnt      <= 5'd0;
                is_div   <= is_dv;
                neg_q    <= is_sgn & (bus.a[31] ^ bus.b[31]);
                neg_r    <= is_sgn & bus.a[31];
                div_zero <= is_dv & b_zero;
                opnd     <= is_dv ? abs_b : abs_a;
                if (!is_dv)
                    acc <= {32'd0, abs_b};
                else if (b_zero)
                    acc <= {32'd0, bus.a};
                else
                    acc <= {32'd0, abs_a};
            end
        end else if (state == RUN) begin
            acc <= acc_nx;
            cnt <= cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (state == FIXUP) begin
            if (!bus.flush) begin
                if (is_div) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end else begin
                    hi_q <= prod[63:32];
                    lo_q <= prod[31:0];
                end
            end
        end else if (go) begin
            if (bus.mdu_op == OP_MTHI)
                hi_q <= bus.a;
            if (bus.mdu_op == OP_MTLO)
                lo_q <= bus.a;
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_mdu;
    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_fail;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    vec_t vecs[12];

    mdu_if bus();

    mdu dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        int qa;
        int qb;
        logic [63:0] r;
        r = 64'd0;
        case (op)
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end
            OP_DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: begin
                if (b == 0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    r  = {32'(qa % qb), 32'(qa / qb)};
                end
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue(op, a, b);
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, ".cycles"}, 32'(n), (op[2] == 1'b0) ? 32'd33 : 32'd0);
        chk({nm, ".hi"}, bus.hi, eh);
        chk({nm, ".lo"}, bus.lo, el);
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        int n;
        n_cmp  = 0;
        n_fail = 0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        bus.mdu_op = 3'd0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        nrst = 1'b0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        vecs[5]  = '{OP_DIVU,  32'd123,       32'd0,        32'd123,       32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[9]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0};
        vecs[10] = '{OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
        vecs[11] = '{OP_DIVU,  32'd0,         32'd5,        32'd0,         32'd0};

        // Reset state, then async reset in the middle of a RUN.
        #23;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.lo", bus.lo, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        do_op("mthi55", OP_MTHI, 32'h55, 32'd0, 32'h55, 32'd0);
        do_op("mtlo66", OP_MTLO, 32'h66, 32'd0, 32'h55, 32'h66);
        issue(OP_MULTU, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.hi", bus.hi, 32'd0);
        chk("midrst.lo", bus.lo, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        do_op("multu3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        for (int i = 0; i < 12; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo);

        // MTHI/MTLO back to back.
        @(negedge clk);
        bus.mdu_op = OP_MTHI;
        bus.a      = 32'hDEAD_BEEF;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b.hi", bus.hi, 32'hDEAD_BEEF);
        chk("b2b.busy0", 32'(bus.busy), 32'd0);
        bus.mdu_op = OP_MTLO;
        bus.a      = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b.lo", bus.lo, 32'h1234_5678);
        chk("b2b.busy1", 32'(bus.busy), 32'd0);

        // Start while busy is ignored.
        issue(OP_DIVU, 32'd100, 32'd7);
        n = 0;
        while (bus.busy && n < 100) begin
            if (n == 5) begin
                bus.mdu_op = OP_MULTU;
                bus.a      = 32'd3;
                bus.b      = 32'd5;
                bus.start  = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end
        chk("ign.cycles", 32'(n), 32'd33);
        chk("ign.hi", bus.hi, 32'd2);
        chk("ign.lo", bus.lo, 32'd14);

        // Flush mid-RUN keeps pre-operation HI/LO.
        do_op("preA", OP_MTHI, 32'hA, 32'd0, 32'hA, 32'd14);
        do_op("preB", OP_MTLO, 32'hB, 32'd0, 32'hA, 32'hB);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush.busy", 32'(bus.busy), 32'd0);
        chk("flush.hi", bus.hi, 32'hA);
        chk("flush.lo", bus.lo, 32'hB);
        repeat (40) @(posedge clk);
        #1;
        chk("flush.later.hi", bus.hi, 32'hA);
        chk("flush.later.lo", bus.lo, 32'hB);

        // Flush beats a simultaneous start in IDLE.
        @(negedge clk);
        bus.mdu_op = OP_MTLO;
        bus.a      = 32'h99;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("sflush.lo", bus.lo, 32'hB);
        chk("sflush.busy", 32'(bus.busy), 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if (op[2] == 1'b0) begin
                r = ref_md(op, ra, rb);
                do_op($sformatf("rnd%0d", i), op, ra, rb, r[63:32], r[31:0]);
            end else if (op == OP_MTHI) begin
                do_op($sformatf("rnd%0d", i), op, ra, rb, ra, mdl_lo);
            end else if (op == OP_MTLO) begin
                do_op($sformatf("rnd%0d", i), op, ra, rb, mdl_hi, ra);
            end else begin
                do_op($sformatf("rnd%0d", i), op, ra, rb, mdl_hi, mdl_lo);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
